muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_iter.sv | 233 +++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit. Multiply uses radix-2 shift-add and divide
// uses restoring division, one bit per cycle. A tag travels from request to result.
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]     CNT_DONE = CW'(XLEN);
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [XLEN-1:0]   ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [TAG_W-1:0]  TAG_ZERO = {TAG_W{1'b0}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_e             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [XLEN-1:0]    out_result_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic [2:0]         op_r;
    logic [TAG_W-1:0]   tag_r;
    logic               neg_r;
    logic               special_r;
    logic [XLEN-1:0]    spec_res_r;
    logic [XLEN-1:0]    opnd_r;
    logic [2*XLEN-1:0]  acc_r;
    logic [CW-1:0]      cnt_r;

    logic               a_sgn_s;
    logic               b_sgn_s;
    logic               neg_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic               special_s;
    logic [XLEN-1:0]    spec_res_s;
    logic [XLEN-1:0]    a_mag_s;
    logic [XLEN-1:0]    b_mag_s;
    logic [XLEN:0]      mul_sum_s;
    logic [2*XLEN-1:0]  mul_next_s;
    logic [XLEN:0]      div_tr_s;
    logic [XLEN:0]      div_diff_s;
    logic [2*XLEN-1:0]  div_next_s;
    logic [2*XLEN-1:0]  prod_s;
    logic [XLEN-1:0]    quo_s;
    logic [XLEN-1:0]    rem_s;
    logic [XLEN-1:0]    final_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_tag    = out_tag_r;

    // Operand signedness per op; neg_s is the sign applied to the final result
    // (quotient/product sign, or the dividend's sign for remainders).
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        neg_s   = 1'b0;
        case (in_op)
            OP_MULH, OP_DIV: begin
                a_sgn_s = in_a[XLEN-1];
                b_sgn_s = in_b[XLEN-1];
                neg_s   = in_a[XLEN-1] ^ in_b[XLEN-1];
            end
            OP_MULHSU: begin
                a_sgn_s = in_a[XLEN-1];
                b_sgn_s = 1'b0;
                neg_s   = in_a[XLEN-1];
            end
            OP_REM: begin
                a_sgn_s = in_a[XLEN-1];
                b_sgn_s = in_b[XLEN-1];
                neg_s   = in_a[XLEN-1];
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
                neg_s   = 1'b0;
            end
        endcase
    end

    // Divide-by-zero and signed-overflow results are known at acceptance.
    always_comb begin
        div_zero_s = (in_b == ZERO);
        div_ovf_s  = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                     (in_a == MOST_NEG) && (in_b == ONES);
        special_s  = in_op[2] && (div_zero_s || div_ovf_s);
        if (div_zero_s) begin
            spec_res_s = in_op[1] ? in_a : ONES;
        end else if (div_ovf_s) begin
            spec_res_s = in_op[1] ? ZERO : MOST_NEG;
        end else begin
            spec_res_s = ZERO;
        end
        a_mag_s = cond_neg(in_a, a_sgn_s);
        b_mag_s = cond_neg(in_b, b_sgn_s);
    end

    // One iteration step; acc_r holds {product_hi, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO});
        mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        div_tr_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_diff_s = div_tr_s - {1'b0, opnd_r};
        if (div_diff_s[XLEN]) begin
            div_next_s = {div_tr_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection once the iterations are complete.
    always_comb begin
        prod_s = cond_neg2(acc_r, neg_r);
        quo_s  = cond_neg(acc_r[XLEN-1:0], neg_r);
        rem_s  = cond_neg(acc_r[2*XLEN-1:XLEN], neg_r);
        case (op_r)
            OP_MUL:                       final_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_s = quo_s;
            OP_REM, OP_REMU:              final_s = rem_s;
            default:                      final_s = ZERO;
        endcase
    end

    // Control FSM with registered handshake and result outputs; flush wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= ZERO;
            out_tag_r    <= TAG_ZERO;
            op_r         <= OP_MUL;
            tag_r        <= TAG_ZERO;
            neg_r        <= 1'b0;
            special_r    <= 1'b0;
            spec_res_r   <= ZERO;
            opnd_r       <= ZERO;
            acc_r        <= {2*XLEN{1'b0}};
            cnt_r        <= CNT_ZERO;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_r    <= ST_CALC;
                        in_ready_r <= 1'b0;
                        op_r       <= in_op;
                        tag_r      <= in_tag;
                        neg_r      <= neg_s;
                        special_r  <= special_s;
                        spec_res_r <= spec_res_s;
                        opnd_r     <= in_op[2] ? b_mag_s : a_mag_s;
                        acc_r      <= {ZERO, (in_op[2] ? a_mag_s : b_mag_s)};
                        cnt_r      <= CNT_ZERO;
                    end
                end
                ST_CALC: begin
                    if (special_r) begin
                        state_r      <= ST_DONE;
                        out_valid_r  <= 1'b1;
                        out_result_r <= spec_res_r;
                        out_tag_r    <= tag_r;
                    end else if (cnt_r == CNT_DONE) begin
                        state_r      <= ST_DONE;
                        out_valid_r  <= 1'b1;
                        out_result_r <= final_s;
                        out_tag_r    <= tag_r;
                    end else begin
                        acc_r <= op_r[2] ? div_next_s : mul_next_s;
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed vector table, hand-written flush/reset/stall
// sequences and randomized ops against a plain-arithmetic RISC-V reference model.
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        out_ready;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic        v32, v16;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic        rdy32, ov32, rdy16, ov16;
    logic [31:0] r32;
    logic [15:0] r16;
    logic [3:0]  t32, t16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v32), .in_ready(rdy32), .in_op(op), .in_a(a32), .in_b(b32), .in_tag(tag),
        .out_valid(ov32), .out_ready(out_ready), .out_result(r32), .out_tag(t32)
    );

    muldiv_iter #(.XLEN(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v16), .in_ready(rdy16), .in_op(op), .in_a(a16), .in_b(b16), .in_tag(tag),
        .out_valid(ov16), .out_ready(out_ready), .out_result(r16), .out_tag(t16)
    );

    typedef struct {
        bit          wide;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // RISC-V M-extension semantics written with ordinary 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input bit wide, input logic [2:0] o,
                                            input logic [31:0] a, input logic [31:0] b);
        int w;
        longint unsigned mask, ua, ub, r;
        longint sa, sb, minv;
        bit ovf;
        w    = wide ? 32 : 16;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ((ua >> (w - 1)) != 64'd0) ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
        sb   = ((ub >> (w - 1)) != 64'd0) ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
        minv = -(longint'(1) << (w - 1));
        ovf  = (sa == minv) && (sb == -64'sd1);
        case (o)
            3'd0: r = $unsigned(sa * sb) & mask;
            3'd1: r = $unsigned((sa * sb) >>> w) & mask;
            3'd2: r = $unsigned((sa * longint'(ub)) >>> w) & mask;
            3'd3: r = ((ua * ub) >> w) & mask;
            3'd4: r = (ub == 64'd0) ? mask : (ovf ? ua : ($unsigned(sa / sb) & mask));
            3'd5: r = (ub == 64'd0) ? mask : (ua / ub);
            3'd6: r = (ub == 64'd0) ? ua : (ovf ? 64'd0 : ($unsigned(sa % sb) & mask));
            default: r = (ub == 64'd0) ? ua : (ua % ub);
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_lat(input bit wide, input logic [2:0] o,
                                   input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, mn;
        ma = wide ? a : {16'd0, a[15:0]};
        mb = wide ? b : {16'd0, b[15:0]};
        mn = wide ? 32'h8000_0000 : 32'h0000_8000;
        if (o[2] && (mb == 32'd0)) return 1;
        if ((o == 3'd4 || o == 3'd6) && ma == mn && mb == (wide ? 32'hFFFF_FFFF : 32'h0000_FFFF)) return 1;
        return wide ? 33 : 17;
    endfunction

    // Called at least 1ns after an edge; accepts on the next edge and measures latency.
    task automatic issue(input bit wide, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tg,
                         output logic [31:0] res, output logic [3:0] rtag, output int lat);
        check("ready before accept", {31'd0, wide ? rdy32 : rdy16}, 32'd1);
        op  = o;
        tag = tg;
        if (wide) begin
            a32 = a; b32 = b; v32 = 1'b1;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; v16 = 1'b1;
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        v16 = 1'b0;
        check("busy after accept", {31'd0, wide ? rdy32 : rdy16}, 32'd0);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            if (wide ? ov32 : ov16) begin
                lat = n - 1;
                break;
            end
            @(posedge clk); #1;
        end
        res  = wide ? r32 : {16'd0, r16};
        rtag = wide ? t32 : t16;
    endtask

    task automatic run_vec(input string nm, input bit wide, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                           input logic [31:0] exp_r, input int exp_lat);
        logic [31:0] res;
        logic [3:0]  rt;
        int          lat;
        issue(wide, o, a, b, tg, res, rt, lat);
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " result"}, res, exp_r);
        check({nm, " tag"}, {28'd0, rt}, {28'd0, tg});
        @(posedge clk); #1;
        check({nm, " idle after handshake"}, {31'd0, wide ? rdy32 : rdy16}, 32'd1);
    endtask

    task automatic watch_quiet(input string nm);
        bit saw;
        saw = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ov32) saw = 1'b1;
        end
        check(nm, {31'd0, saw}, 32'd0);
    endtask

    initial begin
        logic [31:0] res, ra, rb;
        logic [3:0]  rt;
        logic [2:0]  ro;
        int          lat, sel;
        bit          wide;

        vecs[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3,  32'h0000_0000, 33};
        vecs[1]  = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3,  32'hFFFF_FFFE, 33};
        vecs[2]  = '{1'b1, 3'd0, 32'd6,         32'd7,         4'd1,  32'd42,        33};
        vecs[3]  = '{1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2,         4'd2,  32'hFFFF_FFFD, 33};
        vecs[4]  = '{1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2,         4'd4,  32'hFFFF_FFFF, 33};
        vecs[5]  = '{1'b1, 3'd5, 32'h8000_0000, 32'd3,         4'd5,  32'h2AAA_AAAA, 33};
        vecs[6]  = '{1'b1, 3'd5, 32'h0000_1234, 32'd0,         4'd6,  32'hFFFF_FFFF, 1};
        vecs[7]  = '{1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7,  32'h0000_0000, 1};
        vecs[8]  = '{1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8,  32'h8000_0000, 1};
        vecs[9]  = '{1'b1, 3'd7, 32'h0000_1234, 32'd0,         4'd9,  32'h0000_1234, 1};
        vecs[10] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'hFFFF_FFFF, 33};
        vecs[11] = '{1'b1, 3'd7, 32'd100,       32'd7,         4'd11, 32'd2,         33};
        vecs[12] = '{1'b0, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 4'd12, 32'h0000_8000, 1};
        vecs[13] = '{1'b0, 3'd1, 32'h0000_8000, 32'h0000_8000, 4'd13, 32'h0000_4000, 17};

        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
        op = 3'd0; tag = 4'd0; v32 = 1'b0; v16 = 1'b0;
        a32 = 32'd0; b32 = 32'd0; a16 = 16'd0; b16 = 16'd0;
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", {31'd0, ov32}, 32'd0);
        check("reset out_result", r32, 32'd0);
        check("reset out_tag", {28'd0, t32}, 32'd0);
        check("reset out_valid16", {31'd0, ov16}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].wide, vecs[i].op, vecs[i].a,
                    vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 300; i++) begin
            wide = (i < 100);
            ro   = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            sel  = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin
                ra = wide ? 32'h8000_0000 : 32'h0000_8000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) rb = 32'($urandom_range(1, 15));
            run_vec($sformatf("rand%0d op%0d", i, ro), wide, ro, ra, rb, 4'(i),
                    ref_res(wide, ro, ra, rb), ref_lat(wide, ro, ra, rb));
        end

        // Flush in the middle of a divide: no result may ever appear.
        op = 3'd4; a32 = 32'h7FFF_FFFF; b32 = 32'd3; tag = 4'd2; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush ready", {31'd0, rdy32}, 32'd1);
        check("flush valid", {31'd0, ov32}, 32'd0);
        watch_quiet("flush no result");

        // Flush on the same edge as a request suppresses the accept.
        op = 3'd0; a32 = 32'd3; b32 = 32'd3; v32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; flush = 1'b0;
        check("flush beats accept", {31'd0, rdy32}, 32'd1);
        watch_quiet("flush accept no result");

        // Back-pressure: result and tag hold while out_ready is low.
        out_ready = 1'b0;
        issue(1'b1, 3'd0, 32'd6, 32'd7, 4'd5, res, rt, lat);
        check("stall latency", 32'(lat), 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall valid", {31'd0, ov32}, 32'd1);
            check("stall result", r32, 32'd42);
            check("stall tag", {28'd0, t32}, 32'd5);
            check("stall ready", {31'd0, rdy32}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall release valid", {31'd0, ov32}, 32'd0);
        check("stall release ready", {31'd0, rdy32}, 32'd1);

        // Reset pulsed mid-calculation: outputs clear at once, no result afterwards.
        op = 3'd4; a32 = 32'h7FFF_FFFF; b32 = 32'd3; tag = 4'd9; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid", {31'd0, ov32}, 32'd0);
        check("async reset result", r32, 32'd0);
        check("async reset tag", {28'd0, t32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset release ready", {31'd0, rdy32}, 32'd1);
        watch_quiet("reset no result");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
